// File: rtl/elliptic_curve_structs.sv
// Shared curve definitions: a short Weierstrass curve y^2 = x^3 + A*x + B
// over the prime field GF(CURVE_P), the affine point type, the point at
// infinity, the generator, and field arithmetic helpers on reduced elements.
package elliptic_curve_structs;

    localparam int unsigned FW = 8;
    typedef logic [FW-1:0] fe_t;

    localparam fe_t CURVE_P = 8'd97;
    localparam fe_t CURVE_A = 8'd2;
    localparam fe_t CURVE_B = 8'd3;

    typedef struct packed {
        logic inf;
        fe_t  x;
        fe_t  y;
    } curve_point_t;

    localparam curve_point_t inf_point = '{inf: 1'b1, x: '0, y: '0};
    localparam curve_point_t G_POINT   = '{inf: 1'b0, x: 8'd3, y: 8'd6};

    // Operands are assumed already reduced (< CURVE_P).
    function automatic fe_t fe_add(input fe_t a, input fe_t b);
        logic [FW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, CURVE_P})
            s = s - {1'b0, CURVE_P};
        return s[FW-1:0];
    endfunction

    function automatic fe_t fe_neg(input fe_t a);
        return (a == '0) ? '0 : CURVE_P - a;
    endfunction

    function automatic fe_t fe_sub(input fe_t a, input fe_t b);
        return fe_add(a, fe_neg(b));
    endfunction

    function automatic fe_t fe_mul(input fe_t a, input fe_t b);
        logic [2*FW-1:0] prod;
        prod = {{FW{1'b0}}, a} * {{FW{1'b0}}, b};
        return fe_t'(prod % {{FW{1'b0}}, CURVE_P});
    endfunction

endpackage

// File: rtl/msm_accumulator_pkg.sv
// Local definitions for msm_accumulator: the accumulator FSM state type.
package msm_accumulator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_POP      = 3'd1,
        ST_ADD_GO   = 3'd2,
        ST_ADD_WAIT = 3'd3,
        ST_FIN      = 3'd4
    } msm_state_t;

endpackage

// File: rtl/point_add.sv
// Affine elliptic-curve point adder with variable latency.
// Ports:
//   clk   - clock
//   reset - active-high synchronous start; operands sampled from the next cycle
//   P, Q  - operand points, held stable until Done
//   R     - sum P + Q, valid while Done is high
//   Done  - result valid; held until the next reset
// The slope denominator is inverted by Fermat exponentiation (d^(p-2)),
// one square-and-multiply step per cycle. Trivial cases (infinity operand,
// P == -Q) finish in a single cycle.
module point_add
    import elliptic_curve_structs::*;
(
    input  logic         clk,
    input  logic         reset,
    input  curve_point_t P,
    input  curve_point_t Q,
    output curve_point_t R,
    output logic         Done
);

    typedef enum logic [1:0] {A_CHK, A_INV, A_FIN, A_IDLE} add_state_t;

    add_state_t   st, st_n;
    fe_t          num, num_n;
    fe_t          base, base_n;
    fe_t          inv, inv_n;
    fe_t          e, e_n;
    curve_point_t r_n;
    logic         done_n;
    logic         same_x;
    fe_t          lam, x3, y3;

    always_ff @(posedge clk) begin
        if (reset) begin
            st   <= A_CHK;
            Done <= 1'b0;
        end else begin
            st   <= st_n;
            num  <= num_n;
            base <= base_n;
            inv  <= inv_n;
            e    <= e_n;
            R    <= r_n;
            Done <= done_n;
        end
    end

    always_comb begin
        st_n   = st;
        num_n  = num;
        base_n = base;
        inv_n  = inv;
        e_n    = e;
        r_n    = R;
        done_n = Done;
        lam    = '0;
        x3     = '0;
        y3     = '0;
        same_x = (P.x == Q.x);

        case (st)
            A_CHK: begin
                if (P.inf) begin
                    r_n    = Q;
                    done_n = 1'b1;
                    st_n   = A_IDLE;
                end else if (Q.inf) begin
                    r_n    = P;
                    done_n = 1'b1;
                    st_n   = A_IDLE;
                end else if (same_x && ((P.y != Q.y) || (P.y == '0))) begin
                    // Same x on the curve means Q == -P (or a 2-torsion doubling).
                    r_n    = inf_point;
                    done_n = 1'b1;
                    st_n   = A_IDLE;
                end else begin
                    if (same_x) begin
                        num_n  = fe_add(fe_mul(fe_t'(3), fe_mul(P.x, P.x)), CURVE_A);
                        base_n = fe_add(P.y, P.y);
                    end else begin
                        num_n  = fe_sub(Q.y, P.y);
                        base_n = fe_sub(Q.x, P.x);
                    end
                    inv_n = fe_t'(1);
                    e_n   = CURVE_P - fe_t'(2);
                    st_n  = A_INV;
                end
            end
            A_INV: begin
                if (e == '0) begin
                    st_n = A_FIN;
                end else begin
                    if (e[0])
                        inv_n = fe_mul(inv, base);
                    base_n = fe_mul(base, base);
                    e_n    = e >> 1;
                end
            end
            A_FIN: begin
                lam    = fe_mul(num, inv);
                x3     = fe_sub(fe_sub(fe_mul(lam, lam), P.x), Q.x);
                y3     = fe_sub(fe_mul(lam, fe_sub(P.x, x3)), P.y);
                r_n    = '{inf: 1'b0, x: x3, y: y3};
                done_n = 1'b1;
                st_n   = A_IDLE;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/point_fifo.sv
// Small synchronous FIFO of curve points (first-word fall-through head).
// Ports:
//   clk, Reset_n - clock, asynchronous active-low reset (discards contents)
//   push, din    - write din when push && !full
//   pop          - advance head when pop && !empty
//   dout         - current head element
//   full, empty  - occupancy flags
module point_fifo
    import elliptic_curve_structs::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter type         elem_t = curve_point_t
) (
    input  logic  clk,
    input  logic  Reset_n,
    input  logic  push,
    input  elem_t din,
    input  logic  pop,
    output elem_t dout,
    output logic  full,
    output logic  empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0] wr_ptr, rd_ptr;
    elem_t       mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/msm_accumulator.sv
// Multi-scalar-multiplication accumulator: sums a programmed number of
// curve points received over a valid/ready stream using one shared adder.
// Ports:
//   clk, Reset_n       - clock, asynchronous active-low reset
//   start, count       - begin a job summing `count` points (ignored while busy)
//   in_valid, in_ready - input handshake for in_point
//   in_point           - term k_i*P_i from the scalar multiplier
//   busy               - accumulation in progress
//   done, result       - final sum, held until the next start or reset
module msm_accumulator
    import elliptic_curve_structs::*;
    import msm_accumulator_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             in_valid,
    output logic             in_ready,
    input  curve_point_t     in_point,
    output logic             busy,
    output logic             done,
    output curve_point_t     result
);

    msm_state_t       state, state_n;
    logic [CNT_W-1:0] cnt_q, accepted, summed, summed_inc;
    curve_point_t     acc, q_pt, result_q, fifo_head, add_r;
    logic             done_q;
    logic             fifo_full, fifo_empty, fifo_pop, push;
    logic             add_rst, add_done;
    logic             begin_job, load_first, latch_q, take_sum, finish;

    assign busy       = (state != ST_IDLE);
    assign in_ready   = busy && !fifo_full && (accepted < cnt_q);
    assign push       = in_valid && in_ready;
    assign done       = done_q;
    assign result     = result_q;
    assign summed_inc = summed + CNT_W'(1);

    point_fifo #(
        .DEPTH  (DEPTH),
        .elem_t (curve_point_t)
    ) u_fifo (
        .clk     (clk),
        .Reset_n (Reset_n),
        .push    (push),
        .din     (in_point),
        .pop     (fifo_pop),
        .dout    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    point_add u_add (
        .clk   (clk),
        .reset (add_rst),
        .P     (acc),
        .Q     (q_pt),
        .R     (add_r),
        .Done  (add_done)
    );

    always_comb begin
        state_n    = state;
        fifo_pop   = 1'b0;
        add_rst    = 1'b0;
        begin_job  = 1'b0;
        load_first = 1'b0;
        latch_q    = 1'b0;
        take_sum   = 1'b0;
        finish     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    begin_job = 1'b1;
                    state_n   = (count == '0) ? ST_FIN : ST_POP;
                end
            end
            ST_POP: begin
                if (summed == cnt_q) begin
                    state_n = ST_FIN;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (summed == '0) begin
                        // First term seeds the accumulator without an adder call.
                        load_first = 1'b1;
                        state_n    = (cnt_q == CNT_W'(1)) ? ST_FIN : ST_POP;
                    end else begin
                        latch_q = 1'b1;
                        state_n = ST_ADD_GO;
                    end
                end
            end
            ST_ADD_GO: begin
                add_rst = 1'b1;
                state_n = ST_ADD_WAIT;
            end
            ST_ADD_WAIT: begin
                if (add_done) begin
                    take_sum = 1'b1;
                    state_n  = (summed_inc == cnt_q) ? ST_FIN : ST_POP;
                end
            end
            ST_FIN: begin
                finish  = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= ST_IDLE;
            cnt_q    <= '0;
            accepted <= '0;
            summed   <= '0;
            acc      <= inf_point;
            q_pt     <= inf_point;
            done_q   <= 1'b0;
            result_q <= inf_point;
        end else begin
            state <= state_n;
            if (begin_job) begin
                cnt_q    <= count;
                accepted <= '0;
                summed   <= '0;
                acc      <= inf_point;
                done_q   <= 1'b0;
            end
            if (push)
                accepted <= accepted + CNT_W'(1);
            if (load_first) begin
                acc    <= fifo_head;
                summed <= summed_inc;
            end
            if (latch_q)
                q_pt <= fifo_head;
            if (take_sum) begin
                acc    <= add_r;
                summed <= summed_inc;
            end
            if (finish) begin
                result_q <= acc;
                done_q   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_msm_accumulator.sv
// Self-checking bench for msm_accumulator: random jobs of curve points are
// compared against an affine elliptic-curve reference written with integer
// arithmetic (brute-force modular inverse, explicit group-law cases).
module tb_msm_accumulator;
    import elliptic_curve_structs::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 16;
    localparam int          MP    = 97;
    localparam int          MA    = 2;
    localparam int          MB    = 3;

    logic             clk = 1'b0;
    logic             Reset_n;
    logic             start;
    logic [CNT_W-1:0] count;
    logic             in_valid;
    logic             in_ready;
    curve_point_t     in_point;
    logic             busy;
    logic             done;
    curve_point_t     result;

    int n_tests   = 0;
    int n_fail    = 0;
    int add_calls = 0;

    curve_point_t pts[$];
    curve_point_t job_pts[$];

    always #5 clk = ~clk;

    msm_accumulator #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .Reset_n  (Reset_n),
        .start    (start),
        .count    (count),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_point (in_point),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    // Adder invocations: the start pulse lasts exactly one cycle per call.
    always @(negedge clk)
        if (dut.add_rst === 1'b1) add_calls++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_inv(input int d);
        for (int i = 1; i < MP; i++)
            if ((d * i) % MP == 1) return i;
        return 0;
    endfunction

    function automatic curve_point_t m_add(input curve_point_t a, input curve_point_t b);
        int ax, ay, bx, by, num, den, lam, x3, y3;
        curve_point_t r;
        if (a.inf) return b;
        if (b.inf) return a;
        ax = int'(a.x); ay = int'(a.y); bx = int'(b.x); by = int'(b.y);
        if (ax == bx) begin
            if ((ay + by) % MP == 0) return inf_point;
            num = (3 * ax * ax + MA) % MP;
            den = (2 * ay) % MP;
        end else begin
            num = (by - ay + MP) % MP;
            den = (bx - ax + MP) % MP;
        end
        lam = (num * m_inv(den)) % MP;
        x3  = ((lam * lam - ax - bx) % MP + MP) % MP;
        y3  = ((lam * (ax - x3) - ay) % MP + MP) % MP;
        r.inf = 1'b0;
        r.x   = fe_t'(x3);
        r.y   = fe_t'(y3);
        return r;
    endfunction

    function automatic curve_point_t m_smul(input int k, input curve_point_t p);
        curve_point_t r;
        r = inf_point;
        for (int i = 0; i < k; i++) r = m_add(r, p);
        return r;
    endfunction

    function automatic curve_point_t rand_pt();
        if ($urandom_range(0, 9) == 0) return inf_point;
        return pts[$urandom_range(0, pts.size() - 1)];
    endfunction

    task automatic fill_job(input int n);
        job_pts.delete();
        for (int i = 0; i < n; i++) job_pts.push_back(rand_pt());
    endtask

    // Runs one job from job_pts; checks result, handshake counts and adder usage.
    task automatic run_job(input int n, input bit hold, input bit poke, output int stalls);
        int idx, extra, cyc, calls0;
        curve_point_t exp_r;
        exp_r = inf_point;
        for (int i = 0; i < n; i++) exp_r = m_add(exp_r, job_pts[i]);
        calls0 = add_calls;
        idx = 0; extra = 0; cyc = 0; stalls = 0;

        @(posedge clk); #1;
        start = 1'b1;
        count = CNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        count = CNT_W'($urandom);
        check("busy_after_start", busy, 1);
        check("done_cleared", done, 0);
        check("ready_after_start", in_ready, (n > 0) ? 1 : 0);

        while (!done && cyc < 3000) begin
            if (poke && cyc == 3) begin
                start = 1'b1;
                count = CNT_W'($urandom_range(1, 20));
            end else begin
                start = 1'b0;
            end
            if (idx < n && (hold || $urandom_range(0, 99) < 70)) begin
                in_valid = 1'b1;
                in_point = job_pts[idx];
            end else if (idx >= n && hold) begin
                in_valid = 1'b1;
                in_point = rand_pt();
            end else begin
                in_valid = 1'b0;
                in_point = rand_pt();
            end
            if (in_valid && in_ready) begin
                if (idx < n) idx++;
                else extra++;
            end else if (in_valid && idx < n) begin
                stalls++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;

        check("done_timeout", done, 1);
        check("result", result, exp_r);
        check("accepted", idx, n);
        check("extra_accepts", extra, 0);
        check("adder_calls", add_calls - calls0, (n > 1) ? n - 1 : 0);
        check("busy_at_done", busy, 0);
        check("ready_at_done", in_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        check("done_held", done, 1);
        check("result_held", result, exp_r);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls, calls0, idx, cyc;
        curve_point_t g2, g4;

        for (int x = 0; x < MP; x++)
            for (int y = 0; y < MP; y++)
                if ((y * y) % MP == (x * x * x + MA * x + MB) % MP)
                    pts.push_back('{inf: 1'b0, x: fe_t'(x), y: fe_t'(y)});

        Reset_n  = 1'b0;
        start    = 1'b0;
        count    = '0;
        in_valid = 1'b0;
        in_point = inf_point;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, inf_point);
        Reset_n = 1'b1;

        // count == 0: done after the second edge, no transfer, no adder call.
        calls0 = add_calls;
        @(posedge clk); #1;
        start    = 1'b1;
        count    = '0;
        in_valid = 1'b1;
        in_point = G_POINT;
        @(posedge clk); #1;
        start = 1'b0;
        check("c0_busy", busy, 1);
        check("c0_done_early", done, 0);
        check("c0_in_ready", in_ready, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("c0_done", done, 1);
        check("c0_result", result, inf_point);
        check("c0_busy_end", busy, 0);
        check("c0_adder_calls", add_calls - calls0, 0);

        // Single term passes through bit-exact.
        job_pts = '{G_POINT};
        run_job(1, 1'b0, 1'b0, stalls);

        // G + 2G + 4G == 7G.
        g2 = m_add(G_POINT, G_POINT);
        g4 = m_add(g2, g2);
        job_pts = '{G_POINT, g2, g4};
        run_job(3, 1'b0, 1'b0, stalls);
        check("result_7G", result, m_smul(7, G_POINT));

        // Held valid with a slow adder: FIFO fills and backpressures.
        fill_job(6);
        run_job(6, 1'b1, 1'b0, stalls);
        fill_job(8);
        run_job(8, 1'b1, 1'b0, stalls);
        check("fifo_backpressure", (stalls > 0) ? 1 : 0, 1);

        // start while busy is ignored.
        fill_job(5);
        run_job(5, 1'b0, 1'b1, stalls);

        for (int j = 0; j < 6; j++) begin
            int n;
            n = $urandom_range(1, 10);
            fill_job(n);
            run_job(n, 1'($urandom_range(0, 1)), 1'b0, stalls);
        end

        // Reset while the adder is running.
        fill_job(5);
        calls0 = add_calls;
        @(posedge clk); #1;
        start = 1'b1;
        count = CNT_W'(5);
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0; cyc = 0;
        while (add_calls == calls0 && cyc < 200) begin
            in_valid = (idx < 5);
            in_point = (idx < 5) ? job_pts[idx] : inf_point;
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        check("adder_started", (add_calls > calls0) ? 1 : 0, 1);
        Reset_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_result", result, inf_point);
        @(posedge clk);
        @(posedge clk); #1;
        Reset_n = 1'b1;
        job_pts = '{G_POINT, G_POINT};
        run_job(2, 1'b0, 1'b0, stalls);
        check("result_2G", result, g2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
